// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the 12-bit ALU and its two-port arbiter/sequencer:
//   - LARGURA : datapath width (fixed at 12 by ula_12bits)
//   - N_REQ   : number of requesters (fixed at 2)
//   - estado_t: sequencer states
//   - OP_*    : 3-bit opcodes understood by ula_12bits
// Carry convention for OP_SUB: carry_in = 1 means "no borrow in" and
// carry_out = 1 means "no borrow out", so multi-word subtraction chains by
// feeding carry_out of the low word into carry_in of the next word.
// -----------------------------------------------------------------------------
package ula_pkg;

    localparam int LARGURA = 12;
    localparam int N_REQ   = 2;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    localparam logic [2:0] OP_ADD = 3'd0;  // a + b + cin
    localparam logic [2:0] OP_SUB = 3'd1;  // a - b - !cin
    localparam logic [2:0] OP_AND = 3'd2;  // a & b, carry_out = 0
    localparam logic [2:0] OP_OR  = 3'd3;  // a | b, carry_out = 0
    localparam logic [2:0] OP_XOR = 3'd4;  // a ^ b, carry_out = 0
    localparam logic [2:0] OP_NOT = 3'd5;  // ~a,    carry_out = 0
    localparam logic [2:0] OP_SHL = 3'd6;  // {a[10:0], cin}, carry_out = a[11]
    localparam logic [2:0] OP_SHR = 3'd7;  // {cin, a[11:1]}, carry_out = a[0]

endpackage

// File: rtl/ula_12bits.sv
// -----------------------------------------------------------------------------
// ula_12bits
// Purely combinational 12-bit ALU.
// Ports:
//   a, b       in  LARGURA  operands
//   carry_in   in  1        carry / no-borrow / shift-in bit
//   seletor    in  3        opcode (OP_* in ula_pkg)
//   resultado  out LARGURA  result, modulo 2**LARGURA
//   carry_out  out 1        carry / no-borrow / shifted-out bit; 0 for logic ops
// -----------------------------------------------------------------------------
module ula_12bits
    import ula_pkg::*;
(
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic               carry_in,
    input  logic [2:0]         seletor,
    output logic [LARGURA-1:0] resultado,
    output logic               carry_out
);

    logic [LARGURA:0] soma;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        soma      = '0;
        resultado = '0;
        carry_out = 1'b0;
        case (seletor)
            OP_ADD: begin
                soma      = {1'b0, a} + {1'b0, b} + {{LARGURA{1'b0}}, carry_in};
                resultado = soma[LARGURA-1:0];
                carry_out = soma[LARGURA];
            end
            OP_SUB: begin
                // Two's-complement subtract: a + ~b + cin, carry set = no borrow.
                soma      = {1'b0, a} + {1'b0, ~b} + {{LARGURA{1'b0}}, carry_in};
                resultado = soma[LARGURA-1:0];
                carry_out = soma[LARGURA];
            end
            OP_AND: resultado = a & b;
            OP_OR:  resultado = a | b;
            OP_XOR: resultado = a ^ b;
            OP_NOT: resultado = ~a;
            OP_SHL: begin
                resultado = {a[LARGURA-2:0], carry_in};
                carry_out = a[LARGURA-1];
            end
            OP_SHR: begin
                resultado = {carry_in, a[LARGURA-1:1]};
                carry_out = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ula_arbitro.sv
// -----------------------------------------------------------------------------
// ula_arbitro
// Shares one ula_12bits between two requesters. Requests are granted
// round-robin over a valid/ready handshake, operands are registered, the ALU
// runs for one cycle and the result is held on a per-requester valid/ready
// response channel. Each requester keeps its own saved carry flag so it can
// chain multi-word add/subtract sequences across separate requests.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   req_valid  [1:0] request valid per requester
//   req_ready  [1:0] request accepted this cycle (at most one bit high)
//   req_a     [23:0] operand A, {req1, req0}
//   req_b     [23:0] operand B, {req1, req0}
//   req_carry_in [1:0]  explicit carry-in per requester
//   req_usa_carry[1:0]  1 = use the requester's saved carry instead
//   req_seletor  [5:0]  opcode per requester, {req1, req0}
//   rsp_valid  [1:0] response valid per requester
//   rsp_ready  [1:0] response consumed
//   rsp_resultado [11:0] shared result bus, qualified by rsp_valid
//   rsp_carry_out        ALU carry-out of the returned operation
// Timing: handshake in T, ALU in T+1, rsp_valid from T+2.
// -----------------------------------------------------------------------------
module ula_arbitro
    import ula_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*LARGURA-1:0]   req_a,
    input  logic [N_REQ*LARGURA-1:0]   req_b,
    input  logic [N_REQ-1:0]           req_carry_in,
    input  logic [N_REQ-1:0]           req_usa_carry,
    input  logic [N_REQ*3-1:0]         req_seletor,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [LARGURA-1:0]         rsp_resultado,
    output logic                       rsp_carry_out
);

    estado_t            estado;
    logic               ultimo;       // index served last
    logic               g_reg;        // index of the transaction in flight
    logic [N_REQ-1:0]   carry_salvo;  // saved carry per requester
    logic [LARGURA-1:0] a_reg;
    logic [LARGURA-1:0] b_reg;
    logic [2:0]         op_reg;
    logic               cin_reg;

    logic               grant_ok;
    logic               grant_idx;
    logic [LARGURA-1:0] sel_a;
    logic [LARGURA-1:0] sel_b;
    logic [2:0]         sel_op;
    logic               sel_cin;

    logic [LARGURA-1:0] ula_resultado;
    logic               ula_carry;

    // Round-robin grant: a lone requester wins; on a tie the one not served
    // last wins.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_ok  = 1'b1;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant_ok  = 1'b1;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_ok  = 1'b1;
                grant_idx = ~ultimo;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (estado == OCIOSO) && grant_ok)
            req_ready[grant_idx] = 1'b1;
    end

    // Fields of the granted requester.
    always_comb begin
        sel_a   = grant_idx ? req_a[2*LARGURA-1:LARGURA] : req_a[LARGURA-1:0];
        sel_b   = grant_idx ? req_b[2*LARGURA-1:LARGURA] : req_b[LARGURA-1:0];
        sel_op  = grant_idx ? req_seletor[5:3] : req_seletor[2:0];
        sel_cin = req_usa_carry[grant_idx] ? carry_salvo[grant_idx]
                                           : req_carry_in[grant_idx];
    end

    ula_12bits u_ula (
        .a         (a_reg),
        .b         (b_reg),
        .carry_in  (cin_reg),
        .seletor   (op_reg),
        .resultado (ula_resultado),
        .carry_out (ula_carry)
    );

    // NOTE: all state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Operand registers are cleared too: they are few, and it keeps
            // the ALU inputs defined straight out of reset.
            estado        <= OCIOSO;
            ultimo        <= 1'b1;
            g_reg         <= 1'b0;
            carry_salvo   <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            cin_reg       <= 1'b0;
            rsp_valid     <= '0;
            rsp_resultado <= '0;
            rsp_carry_out <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    // grant_ok here is exactly req_valid[g] & req_ready[g].
                    if (grant_ok) begin
                        a_reg   <= sel_a;
                        b_reg   <= sel_b;
                        op_reg  <= sel_op;
                        cin_reg <= sel_cin;
                        g_reg   <= grant_idx;
                        estado  <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    rsp_resultado      <= ula_resultado;
                    rsp_carry_out      <= ula_carry;
                    rsp_valid          <= g_reg ? 2'b10 : 2'b01;
                    carry_salvo[g_reg] <= ula_carry;
                    estado             <= RESPONDE;
                end
                RESPONDE: begin
                    // Only the owner's rsp_ready can close the transaction.
                    if (rsp_ready[g_reg]) begin
                        rsp_valid <= '0;
                        ultimo    <= g_reg;
                        estado    <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbitro.sv
// -----------------------------------------------------------------------------
// tb_ula_arbitro
// Self-checking bench for ula_arbitro: a transaction-level model (grant rule,
// arithmetic result, per-requester carry, response timing by cycle count)
// checked against the DUT every cycle, plus directed vectors with literal
// expected values.
// -----------------------------------------------------------------------------
module tb_ula_arbitro;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [1:0]  req_carry_in;
    logic [1:0]  req_usa_carry;
    logic [5:0]  req_seletor;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [11:0] rsp_resultado;
    logic        rsp_carry_out;

    always #5 clk = ~clk;

    ula_arbitro dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_carry_in  (req_carry_in),
        .req_usa_carry (req_usa_carry),
        .req_seletor   (req_seletor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_resultado (rsp_resultado),
        .rsp_carry_out (rsp_carry_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    int         cyc = 0;
    bit         m_busy = 1'b0;
    int         m_hs = 0;
    bit         m_g = 1'b0;
    logic [12:0] m_pend = '0;
    logic [1:0] m_rsp_valid = '0;
    logic [11:0] m_res = '0;
    logic       m_cout = 1'b0;
    logic [1:0] m_carry = '0;
    bit         m_last = 1'b1;

    // Which request line should be acknowledged right now.
    function automatic logic [1:0] exp_ready();
        if (!rst_n || m_busy || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    // {carry, result} the granted request must produce, from plain arithmetic.
    function automatic logic [12:0] req_result();
        int g, a, b, c, s, res, co;
        logic [2:0] op;
        g  = (exp_ready() == 2'b10) ? 1 : 0;
        a  = int'(g == 1 ? req_a[23:12] : req_a[11:0]);
        b  = int'(g == 1 ? req_b[23:12] : req_b[11:0]);
        op = (g == 1) ? req_seletor[5:3] : req_seletor[2:0];
        c  = int'(req_usa_carry[g] ? m_carry[g] : req_carry_in[g]);
        co = 0;
        res = 0;
        case (op)
            OP_ADD: begin s = a + b + c; res = s % 4096; co = (s >= 4096) ? 1 : 0; end
            OP_SUB: begin s = a - b - (1 - c); co = (s >= 0) ? 1 : 0; res = (s + 4096) % 4096; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = 4095 - a;
            OP_SHL: begin res = (a * 2 + c) % 4096; co = (a >= 2048) ? 1 : 0; end
            default: begin res = a / 2 + c * 2048; co = a % 2; end
        endcase
        return 13'(co * 4096 + res);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_busy      <= 1'b0;
            m_rsp_valid <= '0;
            m_res       <= '0;
            m_cout      <= 1'b0;
            m_carry     <= '0;
            m_last      <= 1'b1;
        end else if (!m_busy) begin
            if (exp_ready() != 2'b00) begin
                m_g    <= (exp_ready() == 2'b10);
                m_pend <= req_result();
                m_busy <= 1'b1;
                m_hs   <= cyc;
            end
        end else if (cyc == m_hs + 1) begin
            m_rsp_valid    <= m_g ? 2'b10 : 2'b01;
            m_res          <= m_pend[11:0];
            m_cout         <= m_pend[12];
            m_carry[m_g]   <= m_pend[12];
        end else if (rsp_ready[m_g]) begin
            m_rsp_valid <= '0;
            m_last      <= m_g;
            m_busy      <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_req_ready", 32'(req_ready), 32'(exp_ready()));
            check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            check("cmp_rsp_resultado", 32'(rsp_resultado), 32'(m_res));
            check("cmp_rsp_carry_out", 32'(rsp_carry_out), 32'(m_cout));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One full transaction for requester idx; entered and left at posedge+1.
    task automatic do_op(input int idx, input logic [11:0] a, input logic [11:0] b,
                         input logic cin, input logic usa, input logic [2:0] op,
                         output logic [11:0] res, output logic co, output int lat);
        bit granted = 1'b0;
        res = '0;
        co  = 1'b0;
        lat = 0;
        req_a[idx*12 +: 12]     = a;
        req_b[idx*12 +: 12]     = b;
        req_seletor[idx*3 +: 3] = op;
        req_carry_in[idx]       = cin;
        req_usa_carry[idx]      = usa;
        req_valid[idx]          = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                granted = 1'b1;
                break;
            end
        end
        if (!granted) begin
            check("grant_timeout", 32'(granted), 32'd1);
            req_valid[idx] = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[idx]) break;
        end
        res = rsp_resultado;
        co  = rsp_carry_out;
        #1 rsp_ready[idx] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[idx] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [11:0] r;
    logic        c;
    int          lat;
    int          gidx[4] = '{-1, -1, -1, -1};
    int          gcyc[4] = '{0, 0, 0, 0};
    int          ng = 0;

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        req_carry_in  = '0;
        req_usa_carry = '0;
        req_seletor   = '0;
        rsp_ready     = '0;

        // Reset state, with a request pending while in reset.
        repeat (2) @(posedge clk);
        #1 req_valid = 2'b01;
        @(negedge clk);
        cmp_en = 1'b1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_resultado", 32'(rsp_resultado), 32'd0);
        check("reset_rsp_carry_out", 32'(rsp_carry_out), 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;

        // Single add with latency.
        do_op(0, 12'h0FF, 12'h001, 1'b0, 1'b0, OP_ADD, r, c, lat);
        check("add_res", 32'(r), 32'h100);
        check("add_cout", 32'(c), 32'd0);
        check("add_latency", 32'(lat), 32'd2);

        // Chained 24-bit add on requester 1.
        do_op(1, 12'hFFF, 12'h001, 1'b0, 1'b0, OP_ADD, r, c, lat);
        check("chain_lo_res", 32'(r), 32'h000);
        check("chain_lo_cout", 32'(c), 32'd1);
        do_op(1, 12'h000, 12'h000, 1'b0, 1'b1, OP_ADD, r, c, lat);
        check("chain_hi_res", 32'(r), 32'h001);
        check("chain_hi_cout", 32'(c), 32'd0);

        // Carry isolation: req0 sets its carry, req1's flag stays 0.
        do_op(0, 12'hFFF, 12'h001, 1'b0, 1'b0, OP_ADD, r, c, lat);
        check("iso_req0_cout", 32'(c), 32'd1);
        do_op(1, 12'h000, 12'h000, 1'b0, 1'b1, OP_ADD, r, c, lat);
        check("iso_req1_res", 32'(r), 32'h000);

        // Subtract with borrow, then chained with saved no-borrow flag.
        do_op(0, 12'h000, 12'h001, 1'b1, 1'b0, OP_SUB, r, c, lat);
        check("sub_res", 32'(r), 32'hFFF);
        check("sub_cout", 32'(c), 32'd0);
        do_op(0, 12'h005, 12'h002, 1'b0, 1'b1, OP_SUB, r, c, lat);
        check("sub_chain_res", 32'(r), 32'h002);
        check("sub_chain_cout", 32'(c), 32'd1);

        // Logic and shift opcodes.
        do_op(1, 12'hA5A, 12'h0FF, 1'b0, 1'b0, OP_XOR, r, c, lat);
        check("xor_res", 32'(r), 32'hAA5);
        do_op(0, 12'h801, 12'h000, 1'b1, 1'b0, OP_SHL, r, c, lat);
        check("shl_res", 32'(r), 32'h003);
        check("shl_cout", 32'(c), 32'd1);

        // Round-robin with both requesting and responses consumed at once.
        do_reset();
        req_a         = {12'h200, 12'h100};
        req_b         = {12'h002, 12'h001};
        req_seletor   = {OP_ADD, OP_ADD};
        req_carry_in  = '0;
        req_usa_carry = '0;
        rsp_ready     = 2'b11;
        req_valid     = 2'b11;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                gidx[ng] = req_ready[1] ? 1 : 0;
                gcyc[ng] = i;
                ng++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rsp_ready = '0;
        check("rr_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(gidx[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);

        // Backpressure: response held 5 cycles, other requester waits.
        do_reset();
        req_a       = {12'h123, 12'h010};
        req_b       = {12'h111, 12'h020};
        req_seletor = {OP_ADD, OP_ADD};
        req_valid   = 2'b11;
        @(negedge clk);
        check("bp_first_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) break;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_res", 32'(rsp_resultado), 32'h030);
        #1 rsp_ready = 2'b10;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_res", 32'(rsp_resultado), 32'h030);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        end
        #1 rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = '0;
        do_op(1, 12'h123, 12'h111, 1'b0, 1'b0, OP_ADD, r, c, lat);
        check("bp_req1_res", 32'(r), 32'h234);

        // Reset during EXECUTA drops the transaction and clears carries.
        do_op(0, 12'hFFF, 12'h001, 1'b0, 1'b0, OP_ADD, r, c, lat);
        do_op(1, 12'hFFF, 12'h001, 1'b0, 1'b0, OP_ADD, r, c, lat);
        check("pre_rst_cout", 32'(c), 32'd1);
        req_a[11:0]   = 12'h001;
        req_b[11:0]   = 12'h001;
        req_seletor[2:0] = OP_ADD;
        req_valid[0]  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        check("rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        do_reset();
        repeat (4) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        do_op(0, 12'h000, 12'h000, 1'b0, 1'b1, OP_ADD, r, c, lat);
        check("rst_req0_res", 32'(r), 32'h000);
        check("rst_req0_lat", 32'(lat), 32'd2);
        do_op(1, 12'h000, 12'h000, 1'b0, 1'b1, OP_ADD, r, c, lat);
        check("rst_req1_res", 32'(r), 32'h000);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
